// File: rtl/uart_reg_responder_pkg.sv
// Shared protocol constants, state encoding and address helper for the UART register responder.
package uart_reg_responder_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_WR      = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_RD      = 8'h52;
  localparam logic [BYTE_W-1:0] RSP_ACK     = 8'h4B;
  localparam logic [BYTE_W-1:0] RSP_NAK     = 8'h3F;
  localparam logic [BYTE_W-1:0] STATUS_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_SEND_ACK  = 3'd3,
    ST_SEND_DATA = 3'd4,
    ST_SEND_NAK  = 3'd5
  } state_e;

  // True when the full address byte selects a bank register.
  function automatic logic addr_in_bank(input logic [BYTE_W-1:0] addr, input int unsigned nreg);
    return (32'(addr) < nreg);
  endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte watchdog: counts while run is high, clears on clr or when idle, flags expiry.
module uart_timeout_ctr #(
  parameter int unsigned LIMIT = 1_000_000,
  parameter int unsigned W     = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  assign expire = run & ~clr & (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || !run || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_reg_responder.sv
// Register-access responder: decodes W/R commands from the RX FIFO, updates the bank,
// and answers through the TX FIFO.
module uart_reg_responder
  import uart_reg_responder_pkg::*;
#(
  parameter int unsigned NREG        = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned TO_W        = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_empty,
  input  logic [BYTE_W-1:0]     r_data,
  output logic                  rd_uart,
  input  logic                  tx_full,
  output logic [BYTE_W-1:0]     w_data,
  output logic                  wr_uart,
  input  logic [BYTE_W-1:0]     status_in,
  output logic [BYTE_W*NREG-1:0] regs_out,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  timeout_err
);

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [BYTE_W-1:0]   addr_q;
  logic [BYTE_W-1:0]   value_q;
  logic [BYTE_W-1:0]   w_data_d;
  logic [BYTE_W-1:0]   rd_val;
  logic                commit;
  logic                snap;
  logic                receiving;
  logic                waiting;
  logic                expire;

  // FIFO strobes follow the handshake directly so a byte moves every cycle the FIFOs allow.
  assign receiving = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign waiting   = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign rd_uart   = receiving & ~rx_empty;
  assign wr_uart   = ((state_q == ST_SEND_ACK) || (state_q == ST_SEND_DATA) ||
                      (state_q == ST_SEND_NAK)) & ~tx_full;
  assign cmd_err   = (state_q == ST_SEND_NAK) & ~tx_full;

  uart_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (waiting),
    .clr     (rd_uart),
    .expire  (expire)
  );

  // Read-value mux, addressed by the byte currently at the RX head.
  always_comb begin
    rd_val = '0;
    if (r_data == STATUS_ADDR) begin
      rd_val = status_in;
    end else begin
      for (int k = 0; k < int'(NREG); k++) begin
        if (r_data == 8'(k)) rd_val = regs_out[BYTE_W*k +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    w_data_d = w_data;
    commit   = 1'b0;
    snap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_uart) begin
          if (r_data == CMD_WR || r_data == CMD_RD) begin
            is_wr_d = (r_data == CMD_WR);
            state_d = ST_GET_ADDR;
          end else begin
            state_d  = ST_SEND_NAK;
            w_data_d = RSP_NAK;
          end
        end
      end
      ST_GET_ADDR: begin
        if (rd_uart) begin
          if (is_wr_q) begin
            state_d = ST_GET_DATA;
          end else if (r_data == STATUS_ADDR || addr_in_bank(r_data, NREG)) begin
            snap     = 1'b1;
            state_d  = ST_SEND_ACK;
            w_data_d = RSP_ACK;
          end else begin
            state_d  = ST_SEND_NAK;
            w_data_d = RSP_NAK;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rd_uart) begin
          // Status address is read-only, so it fails the bank range check here.
          if (addr_in_bank(addr_q, NREG)) begin
            commit   = 1'b1;
            state_d  = ST_SEND_ACK;
            w_data_d = RSP_ACK;
          end else begin
            state_d  = ST_SEND_NAK;
            w_data_d = RSP_NAK;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_ACK: begin
        if (wr_uart) begin
          if (is_wr_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_SEND_DATA;
            w_data_d = value_q;
          end
        end
      end
      ST_SEND_DATA: begin
        if (wr_uart) state_d = ST_IDLE;
      end
      ST_SEND_NAK: begin
        if (wr_uart) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      value_q     <= '0;
      w_data      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      regs_out    <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      w_data      <= w_data_d;
      busy        <= (state_d != ST_IDLE);
      timeout_err <= expire;
      if (state_q == ST_GET_ADDR && rd_uart) addr_q <= r_data;
      if (snap) value_q <= rd_val;
      if (commit) begin
        for (int k = 0; k < int'(NREG); k++) begin
          if (addr_q == 8'(k)) regs_out[BYTE_W*k +: BYTE_W] <= r_data;
        end
      end
    end
  end

endmodule
